// File: rtl/apb_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : apb_irq_aggregator
// Description : AHB-Lite mapped interrupt aggregator with per-source edge/level
//               capture, enable, W1C clear and W1S set; one registered IRQ line
//               plus the index of the lowest-numbered active source.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_irq_aggregator #(
    parameter int NUM_IRQ  = 17,
    parameter int ID_WIDTH = 5
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [11:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic                HREADY,
    output logic [31:0]         HRDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    input  logic [NUM_IRQ-1:0]  IRQ_IN,
    output logic                IRQ_OUT,
    output logic [ID_WIDTH-1:0] IRQ_ID
);

    localparam logic [31:0] c_mask = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << NUM_IRQ) - 32'd1);

    localparam logic [2:0] c_ofs_enable  = 3'd0;
    localparam logic [2:0] c_ofs_type    = 3'd1;
    localparam logic [2:0] c_ofs_pending = 3'd2;
    localparam logic [2:0] c_ofs_clear   = 3'd3;
    localparam logic [2:0] c_ofs_set     = 3'd4;
    localparam logic [2:0] c_ofs_status  = 3'd5;
    localparam logic [2:0] c_ofs_active  = 3'd6;

    // Register state is kept 32 bits wide; bits at and above NUM_IRQ stay 0.
    logic [31:0]         r_enable;
    logic [31:0]         r_type;
    logic [31:0]         r_pend;
    logic [31:0]         r_prev;
    logic                r_irq_out;
    logic [ID_WIDTH-1:0] r_irq_id;

    logic                r_dp_valid;
    logic                r_dp_write;
    logic                r_dp_word;
    logic                r_dp_ok;
    logic [2:0]          r_dp_ofs;

    logic                w_trans_valid;
    logic                w_capture;
    logic                w_addr_ok;
    logic                w_wr;
    logic [31:0]         w_in;
    logic [31:0]         w_wdata;
    logic [31:0]         w_clr;
    logic [31:0]         w_set;
    logic [31:0]         w_rise;
    logic [31:0]         w_pend_next;
    logic [31:0]         w_status;
    logic [31:0]         w_active;
    logic [ID_WIDTH-1:0] w_id;

    assign w_trans_valid = (HTRANS & 2'b10) != 2'b00;
    assign w_capture     = HSEL & w_trans_valid & HREADY;
    assign w_addr_ok     = (HADDR & 12'hFE0) == 12'h000;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_word  <= 1'b0;
            r_dp_ok    <= 1'b0;
            r_dp_ofs   <= 3'd0;
        end else if (HREADY) begin
            r_dp_valid <= w_capture;
            r_dp_write <= HWRITE;
            r_dp_word  <= (HSIZE == 3'b010);
            r_dp_ok    <= w_addr_ok;
            r_dp_ofs   <= HADDR[4:2];
        end
    end

    // A write lands on the edge that ends its data phase.
    assign w_wr    = r_dp_valid & r_dp_write & r_dp_word & r_dp_ok & HREADY;
    assign w_wdata = HWDATA & c_mask;
    assign w_in    = 32'(IRQ_IN);
    assign w_clr   = (w_wr && (r_dp_ofs == c_ofs_clear)) ? w_wdata : 32'd0;
    assign w_set   = (w_wr && (r_dp_ofs == c_ofs_set))   ? w_wdata : 32'd0;
    assign w_rise  = w_in & ~r_prev;

    // Edge sources are sticky with set winning over clear; level sources track the input.
    assign w_pend_next = (r_type & ((r_pend & ~w_clr) | w_rise | w_set))
                       | (~r_type & w_in);

    assign w_status = r_pend & r_enable;

    always_comb begin
        w_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_status[i]) begin
                w_id = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_enable  <= 32'd0;
            r_type    <= 32'd0;
            r_pend    <= 32'd0;
            r_prev    <= 32'd0;
            r_irq_out <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            if (w_wr && (r_dp_ofs == c_ofs_enable)) begin
                r_enable <= w_wdata;
            end
            if (w_wr && (r_dp_ofs == c_ofs_type)) begin
                r_type <= w_wdata;
            end
            r_pend    <= w_pend_next & c_mask;
            r_prev    <= w_in;
            r_irq_out <= |w_status;
            r_irq_id  <= w_id;
        end
    end

    assign w_active = {r_irq_out, 31'(r_irq_id)};

    always_comb begin
        HRDATA = 32'd0;
        if (r_dp_valid && !r_dp_write && r_dp_ok) begin
            case (r_dp_ofs)
                c_ofs_enable:  HRDATA = r_enable;
                c_ofs_type:    HRDATA = r_type;
                c_ofs_pending: HRDATA = r_pend;
                c_ofs_status:  HRDATA = w_status;
                c_ofs_active:  HRDATA = w_active;
                default:       HRDATA = 32'd0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ_OUT   = r_irq_out;
    assign IRQ_ID    = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_apb_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_irq_aggregator
// Description : Self-checking bench: directed scenarios plus randomized bus and
//               interrupt traffic compared every cycle against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_irq_aggregator;

    localparam int          NUM_IRQ  = 17;
    localparam int          ID_WIDTH = 5;
    localparam logic [31:0] c_mask   = 32'h0001_FFFF;

    logic                HCLK = 1'b0;
    logic                HRESETn = 1'b0;
    logic                HSEL = 1'b0;
    logic [11:0]         HADDR = 12'd0;
    logic [1:0]          HTRANS = 2'd0;
    logic                HWRITE = 1'b0;
    logic [2:0]          HSIZE = 3'd2;
    logic [31:0]         HWDATA = 32'd0;
    logic                HREADY = 1'b1;
    logic [31:0]         HRDATA;
    logic                HREADYOUT;
    logic                HRESP;
    logic [NUM_IRQ-1:0]  IRQ_IN = '0;
    logic                IRQ_OUT;
    logic [ID_WIDTH-1:0] IRQ_ID;

    int n_checks = 0;
    int n_errors = 0;

    apb_irq_aggregator #(.NUM_IRQ(NUM_IRQ), .ID_WIDTH(ID_WIDTH)) u_dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .IRQ_IN    (IRQ_IN),
        .IRQ_OUT   (IRQ_OUT),
        .IRQ_ID    (IRQ_ID)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- reference model ----------------
    logic [31:0] r_exp_en, r_exp_type, r_exp_pend, r_exp_prev;
    logic        r_exp_out;
    logic [4:0]  r_exp_id;
    logic        r_exp_dpv, r_exp_dpw, r_exp_dpword, r_exp_dpok;
    logic [2:0]  r_exp_ofs;

    function automatic logic [4:0] f_lowest(input logic [31:0] v);
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) return 5'(i);
        end
        return 5'd0;
    endfunction

    function automatic logic [31:0] f_next_pend(input logic [31:0] p, input logic [31:0] typ,
                                                input logic [31:0] inp, input logic [31:0] prv,
                                                input logic [31:0] clr, input logic [31:0] st);
        logic [31:0] n;
        n = p;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (typ[i]) begin
                if (st[i] || (inp[i] && !prv[i])) n[i] = 1'b1;
                else if (clr[i])                  n[i] = 1'b0;
            end else begin
                n[i] = inp[i];
            end
        end
        return n & c_mask;
    endfunction

    function automatic logic [31:0] f_exp_rdata();
        if (!(r_exp_dpv && !r_exp_dpw && r_exp_dpok)) return 32'd0;
        case (r_exp_ofs)
            3'd0:    return r_exp_en;
            3'd1:    return r_exp_type;
            3'd2:    return r_exp_pend;
            3'd5:    return r_exp_pend & r_exp_en;
            3'd6:    return {r_exp_out, 26'd0, r_exp_id};
            default: return 32'd0;
        endcase
    endfunction

    logic        w_bus_wr;
    logic [31:0] w_in32, w_exp_clr, w_exp_set;
    assign w_bus_wr  = r_exp_dpv & r_exp_dpw & r_exp_dpword & r_exp_dpok & HREADY;
    assign w_in32    = 32'(IRQ_IN);
    assign w_exp_clr = (w_bus_wr && r_exp_ofs == 3'd3) ? (HWDATA & c_mask) : 32'd0;
    assign w_exp_set = (w_bus_wr && r_exp_ofs == 3'd4) ? (HWDATA & c_mask) : 32'd0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_exp_en <= 0; r_exp_type <= 0; r_exp_pend <= 0; r_exp_prev <= 0;
            r_exp_out <= 0; r_exp_id <= 0;
            r_exp_dpv <= 0; r_exp_dpw <= 0; r_exp_dpword <= 0; r_exp_dpok <= 0; r_exp_ofs <= 0;
        end else begin
            r_exp_out <= |(r_exp_pend & r_exp_en);
            r_exp_id  <= f_lowest(r_exp_pend & r_exp_en);
            if (w_bus_wr && r_exp_ofs == 3'd0) r_exp_en   <= HWDATA & c_mask;
            if (w_bus_wr && r_exp_ofs == 3'd1) r_exp_type <= HWDATA & c_mask;
            r_exp_pend <= f_next_pend(r_exp_pend, r_exp_type, w_in32, r_exp_prev,
                                      w_exp_clr, w_exp_set);
            r_exp_prev <= w_in32;
            if (HREADY) begin
                r_exp_dpv    <= HSEL && HTRANS[1];
                r_exp_dpw    <= HWRITE;
                r_exp_dpword <= (HSIZE == 3'b010);
                r_exp_dpok   <= (HADDR[11:5] == 7'd0);
                r_exp_ofs    <= HADDR[4:2];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        chk("model IRQ_OUT", 32'(IRQ_OUT), 32'(r_exp_out));
        chk("model IRQ_ID", 32'(IRQ_ID), 32'(r_exp_id));
        chk("model HRDATA", HRDATA, f_exp_rdata());
        chk("HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("HRESP", 32'(HRESP), 32'd0);
    end

    // ---------------- bus tasks (entered 1 time unit after a rising edge) ----------------
    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
    endtask

    task automatic ahb_write(input logic [11:0] a, input logic [31:0] d, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1; HSIZE = sz;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [11:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        bus_idle();
        d = HRDATA;
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic tick();
        @(posedge HCLK); #1;
    endtask

    initial begin
        logic [31:0] mix;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // 1: everything reads 0 after reset
        for (int k = 0; k < 8; k++) read_chk("reset read", 12'(k * 4), 32'd0);
        read_chk("reset read high addr", 12'h100, 32'd0);

        // 2: edge source pulse, latency, clear
        ahb_write(12'h000, 32'h0001_FFFF, 3'b010);
        ahb_write(12'h004, 32'h0000_0010, 3'b010);
        IRQ_IN = 17'h00010;
        tick();
        IRQ_IN = '0;
        chk("t2 IRQ_OUT one cycle", 32'(IRQ_OUT), 32'd0);
        tick();
        chk("t2 IRQ_OUT two cycles", 32'(IRQ_OUT), 32'd1);
        chk("t2 IRQ_ID", 32'(IRQ_ID), 32'd4);
        read_chk("t2 PENDING", 12'h008, 32'h10);
        read_chk("t2 ACTIVE", 12'h018, 32'h8000_0004);
        ahb_write(12'h00C, 32'h10, 3'b010);
        chk("t2 IRQ_OUT after clear edge", 32'(IRQ_OUT), 32'd1);
        tick();
        chk("t2 IRQ_OUT cleared", 32'(IRQ_OUT), 32'd0);

        // 3: level source ignores CLEAR
        ahb_write(12'h004, 32'h0, 3'b010);
        IRQ_IN = 17'h00100;
        tick(); tick();
        chk("t3 IRQ_OUT", 32'(IRQ_OUT), 32'd1);
        chk("t3 IRQ_ID", 32'(IRQ_ID), 32'd8);
        ahb_write(12'h00C, 32'h100, 3'b010);
        read_chk("t3 PENDING after clear", 12'h008, 32'h100);
        IRQ_IN = '0;
        tick();
        chk("t3 IRQ_OUT one cycle", 32'(IRQ_OUT), 32'd1);
        tick();
        chk("t3 IRQ_OUT dropped", 32'(IRQ_OUT), 32'd0);

        // 4: priority and enable masking
        ahb_write(12'h004, 32'h1008, 3'b010);
        IRQ_IN = 17'h01008;
        tick();
        IRQ_IN = '0;
        tick();
        chk("t4 IRQ_ID both", 32'(IRQ_ID), 32'd3);
        ahb_write(12'h00C, 32'h8, 3'b010);
        tick();
        chk("t4 IRQ_ID after clear", 32'(IRQ_ID), 32'd12);
        ahb_write(12'h000, 32'h0, 3'b010);
        tick();
        chk("t4 IRQ_OUT disabled", 32'(IRQ_OUT), 32'd0);
        read_chk("t4 STATUS", 12'h014, 32'h0);
        read_chk("t4 PENDING", 12'h008, 32'h1000);

        // 5: set beats coincident clear; out-of-range SET
        ahb_write(12'h004, 32'h1FFFF, 3'b010);
        ahb_write(12'h00C, 32'h1FFFF, 3'b010);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 12'h00C; HWRITE = 1'b1; HSIZE = 3'b010;
        tick();
        bus_idle();
        HWDATA = 32'h4;
        IRQ_IN = 17'h00004;
        tick();
        IRQ_IN = '0;
        read_chk("t5 rise vs clear", 12'h008, 32'h4);
        ahb_write(12'h010, 32'h20000, 3'b010);
        read_chk("t5 SET bit17", 12'h008, 32'h4);
        ahb_write(12'h010, 32'h1, 3'b010);
        read_chk("t5 SET bit0", 12'h008, 32'h5);
        read_chk("t5 CLEAR reads 0", 12'h00C, 32'h0);

        // 6: ignored writes, reset mid-operation
        ahb_write(12'h000, 32'hFF, 3'b000);
        read_chk("t6 byte write ignored", 12'h000, 32'h0);
        ahb_write(12'h01C, 32'hFFFF_FFFF, 3'b010);
        read_chk("t6 0x1C reads 0", 12'h01C, 32'h0);
        read_chk("t6 ENABLE unchanged", 12'h000, 32'h0);
        read_chk("t6 TYPE unchanged", 12'h004, 32'h1FFFF);
        ahb_write(12'h000, 32'h1FFFF, 3'b010);
        tick();
        chk("t6 IRQ_OUT before reset", 32'(IRQ_OUT), 32'd1);
        chk("t6 IRQ_ID before reset", 32'(IRQ_ID), 32'd0);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 12'h004; HWRITE = 1'b1; HSIZE = 3'b010;
        tick();
        bus_idle();
        HWDATA = 32'h0;
        HRESETn = 1'b0;
        #1;
        chk("t6 IRQ_OUT in reset", 32'(IRQ_OUT), 32'd0);
        chk("t6 IRQ_ID in reset", 32'(IRQ_ID), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        ahb_write(12'h000, 32'h3, 3'b010);
        read_chk("t6 first write after reset", 12'h000, 32'h3);
        read_chk("t6 TYPE after reset", 12'h004, 32'h0);

        // randomized traffic, checked each cycle by the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge HCLK); #1;
            HREADY = ($urandom_range(0, 9) != 0);
            HSEL   = ($urandom_range(0, 3) != 0);
            HTRANS = 2'($urandom);
            HWRITE = 1'($urandom);
            HSIZE  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b010;
            HADDR  = {(($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'd0), 3'($urandom), 2'b00};
            HWDATA = $urandom;
            mix    = $urandom & $urandom & $urandom;
            IRQ_IN = IRQ_IN ^ 17'(mix);
            if ($urandom_range(0, 999) == 0) begin
                HRESETn = 1'b0;
                #2;
                HRESETn = 1'b1;
            end
        end
        @(posedge HCLK); #1;
        HREADY = 1'b1;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
